ycbcr_y_matrix_3x3: RTL

- Downstream neighbour of the RGB888-to-YCbCr444 converter. Consumes its Y stream plus the vsync/href/clken sync signals.
- Builds a 3x3 luminance neighbourhood per pixel using two line buffers, for later filter and edge-detect stages.
- Runs on the CMOS pixel clock domain and emits window taps with re-timed sync signals.

---
 rtl/ycbcr_y_matrix_3x3_pkg.sv | 11 +
 rtl/ycbcr_y_matrix_3x3_line_ram.sv | 42 ++++
 rtl/ycbcr_y_matrix_3x3.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ycbcr_y_matrix_3x3_pkg.sv
// Shared constants for the Y 3x3 window stage and its downstream filter/edge stages.
// Optional border zeroing is enabled by defining Y_MATRIX_BORDER_ZERO_EN.
package ycbcr_y_matrix_3x3_pkg;

    localparam int Y_DATA_WIDTH     = 8;
    localparam int Y_IMG_HDISP      = 640;
    localparam int Y_IMG_VDISP      = 480;
    // Clocks from accepted pixel to window taps; downstream stages delay sync by this.
    localparam int Y_MATRIX_LATENCY = 2;

endpackage

// File: rtl/ycbcr_y_matrix_3x3_line_ram.sv
// Line delay: DEPTH-deep shift FIFO built as a circular RAM; dout is the sample
// written DEPTH enabled cycles ago, read before the same slot is overwritten.
module y_line_shift_ram #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ptr_q, ptr_d;

    assign dout = mem[ptr_q];

    always_comb begin
        ptr_d = ptr_q;
        if (ce) begin
            ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            mem[ptr_q] <= din;
        end
    end

endmodule

// File: rtl/ycbcr_y_matrix_3x3.sv
// 3x3 luminance neighbourhood generator: two line delays plus per-row tap shifters,
// 2-clk latency. Define Y_MATRIX_BORDER_ZERO_EN to zero taps outside the frame.
module ycbcr_y_matrix_3x3
    import ycbcr_y_matrix_3x3_pkg::*;
#(
    parameter int IMG_HDISP  = Y_IMG_HDISP,
    parameter int IMG_VDISP  = Y_IMG_VDISP,
    parameter int DATA_WIDTH = Y_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  per_frame_vsync,
    input  logic                  per_frame_href,
    input  logic                  per_frame_clken,
    input  logic [DATA_WIDTH-1:0] per_img_Y,
    output logic                  matrix_frame_vsync,
    output logic                  matrix_frame_href,
    output logic                  matrix_frame_clken,
    output logic [DATA_WIDTH-1:0] matrix_p11,
    output logic [DATA_WIDTH-1:0] matrix_p12,
    output logic [DATA_WIDTH-1:0] matrix_p13,
    output logic [DATA_WIDTH-1:0] matrix_p21,
    output logic [DATA_WIDTH-1:0] matrix_p22,
    output logic [DATA_WIDTH-1:0] matrix_p23,
    output logic [DATA_WIDTH-1:0] matrix_p31,
    output logic [DATA_WIDTH-1:0] matrix_p32,
    output logic [DATA_WIDTH-1:0] matrix_p33
);

    localparam int CW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
    localparam int RW = (IMG_VDISP > 1) ? $clog2(IMG_VDISP) : 1;

    logic                  vsync_prev_q, vsync_prev_d;
    logic                  href_prev_q, href_prev_d;
    logic                  armed_q, armed_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [1:0]            vs_pipe_q, vs_pipe_d;
    logic [1:0]            hs_pipe_q, hs_pipe_d;
    logic [1:0]            acc_pipe_q, acc_pipe_d;
    // taps_q[row][age]: row 0 = oldest line, age 0 = newest pixel
    logic [2:0][2:0][DATA_WIDTH-1:0] taps_q, taps_d;
    // win_q[row][col]: row/col 0 = oldest line/pixel
    logic [2:0][2:0][DATA_WIDTH-1:0] win_q, win_d;

    logic [DATA_WIDTH-1:0] line0_dout, line1_dout;
    logic                  arm_now, accept, href_fall;

`ifdef Y_MATRIX_BORDER_ZERO_EN
    logic [CW-1:0]         col_s1_q, col_s1_d;
    logic [RW-1:0]         row_s1_q, row_s1_d;
`endif

    y_line_shift_ram #(.DEPTH(IMG_HDISP), .WIDTH(DATA_WIDTH)) u_line0 (
        .clk  (clk),
        .rst_n(rst_n),
        .ce   (accept),
        .din  (per_img_Y),
        .dout (line0_dout)
    );

    y_line_shift_ram #(.DEPTH(IMG_HDISP), .WIDTH(DATA_WIDTH)) u_line1 (
        .clk  (clk),
        .rst_n(rst_n),
        .ce   (accept),
        .din  (line0_dout),
        .dout (line1_dout)
    );

    always_comb begin
        // After reset, input stays ignored until a fresh frame starts.
        arm_now   = per_frame_vsync & ~vsync_prev_q;
        accept    = per_frame_clken & per_frame_href & (armed_q | arm_now);
        href_fall = href_prev_q & ~per_frame_href;

        vsync_prev_d = per_frame_vsync;
        href_prev_d  = per_frame_href;
        armed_d      = armed_q | arm_now;

        col_d = col_q;
        if (!per_frame_href) begin
            col_d = '0;
        end else if (accept && col_q != CW'(IMG_HDISP - 1)) begin
            col_d = col_q + CW'(1);
        end

        row_d = row_q;
        if (!per_frame_vsync) begin
            row_d = '0;
        end else if (href_fall && row_q != RW'(IMG_VDISP - 1)) begin
            row_d = row_q + RW'(1);
        end

        vs_pipe_d  = {vs_pipe_q[0], per_frame_vsync};
        hs_pipe_d  = {hs_pipe_q[0], per_frame_href};
        acc_pipe_d = {acc_pipe_q[0], accept};

        taps_d = taps_q;
        if (accept) begin
            taps_d[0] = {taps_q[0][1:0], line1_dout};
            taps_d[1] = {taps_q[1][1:0], line0_dout};
            taps_d[2] = {taps_q[2][1:0], per_img_Y};
        end

        win_d = win_q;
        if (acc_pipe_q[0]) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_d[r][c] = taps_q[r][2-c];
                end
            end
`ifdef Y_MATRIX_BORDER_ZERO_EN
            if (row_s1_q == '0) begin
                win_d[0] = '0;
                win_d[1] = '0;
            end else if (row_s1_q == RW'(1)) begin
                win_d[0] = '0;
            end
            for (int r = 0; r < 3; r++) begin
                if (col_s1_q == '0) begin
                    win_d[r][0] = '0;
                    win_d[r][1] = '0;
                end else if (col_s1_q == CW'(1)) begin
                    win_d[r][0] = '0;
                end
            end
`endif
        end

`ifdef Y_MATRIX_BORDER_ZERO_EN
        col_s1_d = accept ? col_q : col_s1_q;
        row_s1_d = accept ? row_q : row_s1_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_prev_q <= 1'b1;
            href_prev_q  <= 1'b0;
            armed_q      <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            vs_pipe_q    <= '0;
            hs_pipe_q    <= '0;
            acc_pipe_q   <= '0;
            taps_q       <= '0;
            win_q        <= '0;
        end else begin
            vsync_prev_q <= vsync_prev_d;
            href_prev_q  <= href_prev_d;
            armed_q      <= armed_d;
            col_q        <= col_d;
            row_q        <= row_d;
            vs_pipe_q    <= vs_pipe_d;
            hs_pipe_q    <= hs_pipe_d;
            acc_pipe_q   <= acc_pipe_d;
            taps_q       <= taps_d;
            win_q        <= win_d;
        end
    end

`ifdef Y_MATRIX_BORDER_ZERO_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_s1_q <= '0;
            row_s1_q <= '0;
        end else begin
            col_s1_q <= col_s1_d;
            row_s1_q <= row_s1_d;
        end
    end
`endif

    assign matrix_frame_vsync = vs_pipe_q[1];
    assign matrix_frame_href  = hs_pipe_q[1];
    assign matrix_frame_clken = acc_pipe_q[1];

    assign matrix_p11 = win_q[0][0];
    assign matrix_p12 = win_q[0][1];
    assign matrix_p13 = win_q[0][2];
    assign matrix_p21 = win_q[1][0];
    assign matrix_p22 = win_q[1][1];
    assign matrix_p23 = win_q[1][2];
    assign matrix_p31 = win_q[2][0];
    assign matrix_p32 = win_q[2][1];
    assign matrix_p33 = win_q[2][2];

endmodule
